// File: rtl/rasterizer_pkg.sv
// Shared types for the rasterizer fragment path.
package rasterizer_pkg;

  // The fragment record has fixed field widths; frag_span_gen's EW/XY_W defaults match these.
  localparam int FRAG_XY_W = 16;
  localparam int FRAG_EW   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [FRAG_XY_W-1:0] x;
    logic [FRAG_XY_W-1:0] y;
    logic [FRAG_EW-1:0]   w0;
    logic [FRAG_EW-1:0]   w1;
    logic [FRAG_EW-1:0]   w2;
    logic                 covered;
  } fragment_t;

endpackage

// File: rtl/frag_fifo.sv
// Synchronous FIFO, depth 2^LG, full/empty from an extra pointer wrap bit.
module frag_fifo #(
  parameter int DW = 8,
  parameter int LG = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int DEPTH = 1 << LG;

  logic [DW-1:0] mem_q [DEPTH];
  logic [LG:0]   wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[LG] != rptr_q[LG]) && (wptr_q[LG-1:0] == rptr_q[LG-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[LG-1:0]];

  // Pointer update; flush and reset both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (LG+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (LG+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q[LG-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/frag_span_gen.sv
// Bounding-box raster walker: one pixel per cycle, edge functions stepped incrementally.
module frag_span_gen
  import rasterizer_pkg::*;
#(
  parameter int EW              = 32,
  parameter int XY_W            = 16,
  parameter int LG_FRAG_FIFO_SZ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            cull_mode,
  input  logic [XY_W-1:0] xmin,
  input  logic [XY_W-1:0] xmax,
  input  logic [XY_W-1:0] ymin,
  input  logic [XY_W-1:0] ymax,
  input  logic [EW-1:0]   l0_dx,
  input  logic [EW-1:0]   l1_dx,
  input  logic [EW-1:0]   l2_dx,
  input  logic [EW-1:0]   l0_dy,
  input  logic [EW-1:0]   l1_dy,
  input  logic [EW-1:0]   l2_dy,
  input  logic [EW-1:0]   w0_00,
  input  logic [EW-1:0]   w1_00,
  input  logic [EW-1:0]   w2_00,
  input  logic            pop_frag,
  output logic            frag_val,
  output fragment_t       frag,
  output logic            busy,
  output logic            done,
  output logic [31:0]     frag_count
);

  state_e          state_q, state_d;
  logic [XY_W-1:0] x_q, x_d, y_q, y_d;
  logic [XY_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic            cull_q, cull_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [EW-1:0]   w_q [3];
  logic [EW-1:0]   w_d [3];
  logic [EW-1:0]   roww_q [3];
  logic [EW-1:0]   roww_d [3];
  logic [EW-1:0]   ldx_q [3];
  logic [EW-1:0]   ldx_d [3];
  logic [EW-1:0]   ldy_q [3];
  logic [EW-1:0]   ldy_d [3];

  logic      covered, emit, push, flush, done_c;
  logic      fifo_empty, fifo_full;
  fragment_t push_frag;
  logic [$bits(fragment_t)-1:0] fifo_rdata;

  assign covered = !w_q[0][EW-1] && !w_q[1][EW-1] && !w_q[2][EW-1];
  assign emit    = !cull_q || covered;

  assign push_frag = '{x: FRAG_XY_W'(x_q), y: FRAG_XY_W'(y_q),
                       w0: FRAG_EW'(w_q[0]), w1: FRAG_EW'(w_q[1]), w2: FRAG_EW'(w_q[2]),
                       covered: covered};

  // Next-state: latch on start, walk the box in raster order, drain then signal done.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    cull_d  = cull_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      w_d[i]    = w_q[i];
      roww_d[i] = roww_q[i];
      ldx_d[i]  = ldx_q[i];
      ldy_d[i]  = ldy_q[i];
    end
    push   = 1'b0;
    flush  = 1'b0;
    done_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          x_d = xmin; y_d = ymin;
          xmin_d = xmin; xmax_d = xmax; ymax_d = ymax;
          cull_d = cull_mode;
          cnt_d  = '0;
          ldx_d[0] = l0_dx; ldx_d[1] = l1_dx; ldx_d[2] = l2_dx;
          ldy_d[0] = l0_dy; ldy_d[1] = l1_dy; ldy_d[2] = l2_dy;
          w_d[0] = w0_00; w_d[1] = w1_00; w_d[2] = w2_00;
          roww_d[0] = w0_00; roww_d[1] = w1_00; roww_d[2] = w2_00;
          state_d = ((xmin > xmax) || (ymin > ymax)) ? DRAIN : STEP;
        end
      end
      STEP: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (!(emit && fifo_full)) begin
          push = emit;
          if (emit) cnt_d = cnt_q + 32'd1;
          if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + XY_W'(1);
            for (int unsigned i = 0; i < 3; i++) begin
              roww_d[i] = roww_q[i] - ldx_q[i];
              w_d[i]    = roww_q[i] - ldx_q[i];
            end
            if (y_q == ymax_q) state_d = DRAIN;
          end else begin
            x_d = x_q + XY_W'(1);
            for (int unsigned i = 0; i < 3; i++) w_d[i] = w_q[i] + ldy_q[i];
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (fifo_empty) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0; y_q <= '0;
      xmin_q <= '0; xmax_q <= '0; ymax_q <= '0;
      cull_q <= 1'b0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        w_q[i] <= '0; roww_q[i] <= '0; ldx_q[i] <= '0; ldy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymax_q <= ymax_d;
      cull_q <= cull_d;
      cnt_q  <= cnt_d;
      for (int unsigned i = 0; i < 3; i++) begin
        w_q[i] <= w_d[i]; roww_q[i] <= roww_d[i]; ldx_q[i] <= ldx_d[i]; ldy_q[i] <= ldy_d[i];
      end
    end
  end

  frag_fifo #(
    .DW($bits(fragment_t)),
    .LG(LG_FRAG_FIFO_SZ)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (push_frag),
    .pop_i   (pop_frag),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign frag       = fragment_t'(fifo_rdata);
  assign frag_val   = !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign done       = done_c && !rst;
  assign frag_count = cnt_q;

endmodule

// File: tb/tb_frag_span_gen.sv
// Self-checking bench: expected fragment list computed in closed form per pixel.
module tb_frag_span_gen;
  import rasterizer_pkg::*;

  localparam int EW = 32;
  localparam int XY_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, cull_mode = 1'b0, pop_frag = 1'b0;
  logic [XY_W-1:0] xmin = '0, xmax = '0, ymin = '0, ymax = '0;
  logic [EW-1:0] l0_dx = '0, l1_dx = '0, l2_dx = '0, l0_dy = '0, l1_dy = '0, l2_dy = '0;
  logic [EW-1:0] w0_00 = '0, w1_00 = '0, w2_00 = '0;
  logic frag_val, busy, done;
  fragment_t frag;
  logic [31:0] frag_count;

  frag_span_gen #(.EW(EW), .XY_W(XY_W), .LG_FRAG_FIFO_SZ(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cull_mode(cull_mode),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .l0_dx(l0_dx), .l1_dx(l1_dx), .l2_dx(l2_dx),
    .l0_dy(l0_dy), .l1_dy(l1_dy), .l2_dy(l2_dy),
    .w0_00(w0_00), .w1_00(w1_00), .w2_00(w2_00),
    .pop_frag(pop_frag), .frag_val(frag_val), .frag(frag),
    .busy(busy), .done(done), .frag_count(frag_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, last_pop_cyc = -1, done_cyc = -1, done_cnt = 0, n_exp = 0;
  int unsigned pop_pct = 100;
  bit check_en = 1'b0;
  fragment_t exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every bbox pixel in raster order, edge value by direct formula.
  function automatic int build();
    logic [31:0] w [3];
    logic [31:0] dxa [3];
    logic [31:0] dya [3];
    logic [31:0] w00 [3];
    fragment_t f;
    int n = 0;
    dxa = '{l0_dx, l1_dx, l2_dx};
    dya = '{l0_dy, l1_dy, l2_dy};
    w00 = '{w0_00, w1_00, w2_00};
    exp_q.delete();
    for (int y = int'(ymin); y <= int'(ymax); y++) begin
      for (int x = int'(xmin); x <= int'(xmax); x++) begin
        for (int i = 0; i < 3; i++)
          w[i] = w00[i] + 32'(x - int'(xmin)) * dya[i] - 32'(y - int'(ymin)) * dxa[i];
        f.x = 16'(x); f.y = 16'(y);
        f.w0 = w[0]; f.w1 = w[1]; f.w2 = w[2];
        f.covered = !w[0][31] && !w[1][31] && !w[2][31];
        if (!cull_mode || f.covered) begin
          exp_q.push_back(f);
          n++;
        end
      end
    end
    return n;
  endfunction

  // Compare every popped head fragment; track done pulses.
  always @(negedge clk) begin
    if (check_en) begin
      if (frag_val && pop_frag) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frag: got %0h expected none", frag);
        end else begin
          chk("frag", frag, exp_q.pop_front());
          last_pop_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_with_queue_empty", exp_q.size(), 0);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    pop_frag = ($urandom_range(99) < pop_pct);
  end

  task automatic launch();
    n_exp = build();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_check(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) ok = 1'b1;
    end
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_frag_count"}, frag_count, n_exp);
    chk({tag, "_all_popped"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic set_flat(input int x0, input int x1, input int y0, input int y1, input logic cm);
    xmin = 16'(x0); xmax = 16'(x1); ymin = 16'(y0); ymax = 16'(y1); cull_mode = cm;
    l0_dx = '0; l1_dx = '0; l2_dx = '0; l0_dy = '0; l1_dy = '0; l2_dy = '0;
    w0_00 = 32'd100; w1_00 = 32'd100; w2_00 = 32'd100;
  endtask

  function automatic logic [31:0] rnd_val(input int unsigned mag);
    if ($urandom_range(3) == 0) return $urandom;
    return 32'($urandom_range(2*mag)) - 32'(mag);
  endfunction

  task automatic rand_setup();
    int unsigned wd, ht, bx, by;
    wd = $urandom_range(5); ht = $urandom_range(4);
    bx = ($urandom_range(3) == 0) ? 65535 - wd : $urandom_range(100);
    by = ($urandom_range(3) == 0) ? 65535 - ht : $urandom_range(100);
    xmin = 16'(bx); xmax = 16'(bx + wd); ymin = 16'(by); ymax = 16'(by + ht);
    if ($urandom_range(9) == 0) begin xmin = 16'd10; xmax = 16'd3; end
    cull_mode = $urandom_range(1);
    w0_00 = rnd_val(64); w1_00 = rnd_val(64); w2_00 = rnd_val(64);
    l0_dx = rnd_val(24); l1_dx = rnd_val(24); l2_dx = rnd_val(24);
    l0_dy = rnd_val(24); l1_dy = rnd_val(24); l2_dy = rnd_val(24);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_frag_val", frag_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frag_count", frag_count, 0);
    check_en = 1'b1;

    // 2x2 box, all inside, pop always.
    pop_pct = 100;
    set_flat(0, 1, 0, 1, 1'b0);
    k = build();
    chk("pin_2x2_n", k, 4);
    chk("pin_2x2_first", {exp_q[0].x, exp_q[0].y, exp_q[0].covered}, {16'd0, 16'd0, 1'b1});
    chk("pin_2x2_second", {exp_q[1].x, exp_q[1].y}, {16'd1, 16'd0});
    chk("pin_2x2_last", {exp_q[3].x, exp_q[3].y, exp_q[3].covered}, {16'd1, 16'd1, 1'b1});
    launch();
    @(negedge clk); chk("latency_n1", frag_val, 0);
    @(negedge clk); chk("latency_n2", frag_val, 1);
    run_check("box2x2", 50);
    chk("box2x2_done_after_last_pop", done_cyc, last_pop_cyc + 1);
    chk("box2x2_count_lit", frag_count, 4);

    // Single row with cull: w0 goes 1,0,-1,-2.
    set_flat(0, 3, 0, 0, 1'b1);
    w0_00 = 32'd1; l0_dy = 32'hFFFF_FFFF;
    k = build();
    chk("pin_cull_n", k, 2);
    chk("pin_cull_0", {exp_q[0].x, exp_q[0].w0}, {16'd0, 32'd1});
    chk("pin_cull_1", {exp_q[1].x, exp_q[1].w0}, {16'd1, 32'd0});
    launch();
    run_check("cull_row", 50);
    chk("cull_row_count_lit", frag_count, 2);

    // Backpressure: depth-4 FIFO fills and stalls.
    pop_pct = 0;
    set_flat(0, 7, 0, 0, 1'b0);
    launch();
    repeat (20) @(negedge clk);
    #1;
    chk("stall_count", frag_count, 4);
    chk("stall_busy", busy, 1);
    chk("stall_frag_val", frag_val, 1);
    chk("stall_no_done", done_cnt, 0);
    pop_pct = 100;
    run_check("stall_drain", 50);

    // Abort after the 4th push of a 3x3 run.
    set_flat(0, 2, 0, 2, 1'b0);
    launch();
    for (int i = 0; i < 50 && frag_count != 4; i++) @(negedge clk);
    chk("abort_reached4", frag_count, 4);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_frag_val", frag_val, 0);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    #1 chk("abort_no_done", done_cnt, 0);
    launch();
    run_check("after_abort", 60);
    chk("after_abort_count_lit", frag_count, 9);

    // Empty box.
    set_flat(5, 4, 0, 0, 1'b0);
    launch();
    run_check("empty_box", 2);
    chk("empty_box_count_lit", frag_count, 0);

    // Reset with 3 queued fragments.
    pop_pct = 0;
    set_flat(0, 7, 0, 0, 1'b0);
    launch();
    for (int i = 0; i < 50 && frag_count != 3; i++) @(negedge clk);
    chk("rst_mid_reached3", frag_count, 3);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_frag_val", frag_val, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", frag_count, 0);
    chk("rst_mid_done", done, 0);
    exp_q.delete();
    #1 chk("rst_mid_no_done", done_cnt, 0);

    // Randomized triangles; inputs scrambled after start to exercise latching.
    for (int t = 0; t < 40; t++) begin
      pop_pct = $urandom_range(20, 100);
      rand_setup();
      launch();
      rand_setup();
      run_check("rand", 2000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frag_span_gen.md
FRAG_SPAN_GEN -- requirements
Module: frag_span_gen

Interface
REQ-001 SHALL have parameter EW, default 32, meaning edge-function width in bits (two's-complement fixed point).
REQ-002 SHALL have parameter XY_W, default 16, meaning pixel-coordinate width (unsigned).
REQ-003 SHALL have parameter LG_FRAG_FIFO_SZ, default 4, meaning log2 of output FIFO depth.
REQ-004 SHALL have port: clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: start  in  1  begin a triangle; sampled only in IDLE.
REQ-007 SHALL have port: abort  in  1  cancel current triangle and flush FIFO.
REQ-008 SHALL have port: cull_mode  in  1  1 = emit covered pixels only; 0 = emit every bbox pixel.
REQ-009 SHALL have ports: xmin, xmax, ymin, ymax  in  XY_W  inclusive bounding box.
REQ-010 SHALL have ports: l0_dx, l1_dx, l2_dx, l0_dy, l1_dy, l2_dy  in  EW  edge steps per y and per x.
REQ-011 SHALL have ports: w0_00, w1_00, w2_00  in  EW  edge values at (xmin, ymin).
REQ-012 SHALL have port: pop_frag  in  1  consumer takes head fragment.
REQ-013 SHALL have ports: frag_val  out  1  FIFO non-empty; frag  out  fragment_t  head entry {x, y, w0, w1, w2, covered}.
REQ-014 SHALL have ports: busy  out  1  state != IDLE; done  out  1  one-cycle completion pulse; frag_count  out  32  fragments pushed since last accepted start.

Function
REQ-015 SHALL use states IDLE, STEP, DRAIN.
REQ-016 IDLE + start: latch all inputs, set x=xmin, y=ymin, w_i=row_w_i=w_i_00, clear frag_count, go STEP; if xmin>xmax or ymin>ymax, go DRAIN instead.
REQ-017 STEP: evaluate one pixel per cycle; covered = all three w_i >= 0 (signed; zero counts as inside).
REQ-018 STEP pixel SHALL be pushed iff (cull_mode==0 or covered) and FIFO not full; a pixel that is not emitted is consumed without needing FIFO space.
REQ-019 FIFO full (registered) with a pixel to emit SHALL stall: no advance, no push, even if pop_frag is asserted in that cycle.
REQ-020 Advance within a row: x+=1, w_i += l_i_dy.
REQ-021 Row end (x==xmax): x=xmin, y+=1, row_w_i -= l_i_dx, w_i = new row_w_i.
REQ-022 Last pixel (x==xmax, y==ymax) processed: go DRAIN.
REQ-023 DRAIN: when FIFO is empty, pulse done for one cycle, go IDLE.
REQ-024 Edge arithmetic SHALL be EW-bit modular two's complement; overflow wraps and is not flagged.
REQ-025 Latency: with start in cycle N, first emitted fragment SHALL raise frag_val in cycle N+2.
REQ-026 Traversal order SHALL be raster order: x ascending within a row, rows y ascending.
REQ-027 pop_frag with FIFO empty SHALL be ignored.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in any non-IDLE state: next cycle IDLE, FIFO emptied, no done pulse; abort has priority over start.
REQ-030 frag_count SHALL increment once per push, wrapping at 2^32.

Reset
REQ-031 rst SHALL force state IDLE, FIFO pointers 0, frag_val 0, busy 0, done 0, frag_count 0, and all latched coordinates and edge values 0.
REQ-032 rst mid-triangle SHALL discard all queued fragments and emit no done pulse.

Structure
REQ-033 fragment_t and the state enum SHALL live in shared package rasterizer_pkg.
REQ-034 The output queue SHALL be a separate parametrised synchronous FIFO sub-module, frag_fifo (depth 2^LG_FRAG_FIFO_SZ, wrap-bit full/empty).

Verification
REQ-035 Bbox 0..1 x 0..1, all w_i_00=100, steps 0, cull_mode=0, pop_frag=1 -> frags (0,0),(1,0),(0,1),(1,1), each covered=1; done 1 cycle after the last pop; frag_count=4.
REQ-036 Row x=0..3, y=0, w0_00=1, l0_dy=-1, w1/w2_00=100, cull_mode=1 -> only x=0 (w0=1) and x=1 (w0=0) emitted; frag_count=2.
REQ-037 LG_FRAG_FIFO_SZ=2, row x=0..7, pop_frag=0 -> exactly 4 frags queued, busy=1, no done; then pop continuously -> x=4..7 follow, done pulses once.
REQ-038 3x3 bbox, abort asserted after the 4th push -> frag_val=0 and busy=0 next cycle, no done; a subsequent start produces a full 9-fragment run.
REQ-039 xmin=5, xmax=4 start -> no fragment, done pulse within 2 cycles, frag_count=0.
REQ-040 rst asserted while 3 frags are queued -> next cycle frag_val=0, busy=0, frag_count=0, done=0.
